alu_req_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 37 +++
 rtl/alu_tag_fifo.sv | 79 +++++++
 rtl/alu_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU request arbiter: opcode, operand-B select,
// request bundle and arbiter state encoding.
package alu_arb_pkg;

  localparam int ALU_DATA_WIDTH = 8;
  localparam int OP_WIDTH       = 4;
  localparam int MOVI_WIDTH     = 2;

  typedef logic [OP_WIDTH-1:0] op_t;

  typedef enum logic [MOVI_WIDTH-1:0] {
    REG_B = 2'd0,
    MEM   = 2'd1,
    IMM   = 2'd2,
    RSVD  = 2'd3
  } movi_t;

  typedef struct packed {
    op_t                       op;
    movi_t                     movi;
    logic [ALU_DATA_WIDTH-1:0] reg_a;
    logic [ALU_DATA_WIDTH-1:0] reg_b;
    logic [ALU_DATA_WIDTH-1:0] mem;
    logic [ALU_DATA_WIDTH-1:0] imm;
  } alu_req_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_t;

  // True for the reserved operand-B select code.
  function automatic logic is_rsvd_movi(input movi_t movi);
    return (movi == RSVD);
  endfunction

endpackage

// File: rtl/alu_tag_fifo.sv
// In-order FIFO of requester tags for operations currently inside the ALU.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_tag_fifo
  import alu_arb_pkg::*;
#(
  parameter int TAG_WIDTH = 2,
  parameter int DEPTH     = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [TAG_WIDTH-1:0] push_tag,
  input  logic                 pop,
  output logic [TAG_WIDTH-1:0] pop_tag,
  output logic                 full,
  output logic                 empty,
  output logic [CW-1:0]        count
);

  logic [TAG_WIDTH-1:0] mem_q [DEPTH];
  logic [TAG_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 do_push_s;
  logic                 do_pop_s;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign count   = count_q;
  assign pop_tag = mem_q[rd_ptr_q];

  // A push into a full FIFO is only honoured when a pop frees the head slot.
  always_comb begin
    do_push_s = push && (!full || pop);
    do_pop_s  = pop && !empty;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {TAG_WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters. The granted
// operation is held on the ALU port until accepted; requester tags are queued
// in issue order so each result is steered back to its originator.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [NUM_REQ-1:0]              REQ_VLD,
  output logic [NUM_REQ-1:0]              REQ_RDY,
  input  logic [NUM_REQ*4-1:0]            REQ_OP,
  input  logic [NUM_REQ*2-1:0]            REQ_MOVI,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_REG_A,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_REG_B,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_MEM,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   REQ_IMM,
  output logic                            ALU_ACT,
  output logic [3:0]                      ALU_OP,
  output logic [1:0]                      ALU_MOVI,
  output logic [DATA_WIDTH-1:0]           ALU_REG_A,
  output logic [DATA_WIDTH-1:0]           ALU_REG_B,
  output logic [DATA_WIDTH-1:0]           ALU_MEM,
  output logic [DATA_WIDTH-1:0]           ALU_IMM,
  input  logic                            ALU_RDY,
  input  logic [DATA_WIDTH-1:0]           ALU_EX,
  input  logic                            ALU_EX_VLD,
  output logic [NUM_REQ-1:0]              RES_VLD,
  output logic [DATA_WIDTH-1:0]           RES_DATA,
  output logic [$clog2(MAX_OUTSTANDING):0] OUTSTANDING,
  output logic                            ERR_SPURIOUS,
  output logic                            ERR_MOVI
);

  localparam logic [ID_WIDTH:0] NUM_REQ_EXT = (ID_WIDTH+1)'(NUM_REQ);

  arb_state_t            state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  alu_act_q, alu_act_d;
  op_t                   op_q, op_d;
  movi_t                 movi_q, movi_d;
  logic [DATA_WIDTH-1:0] reg_a_q, reg_a_d;
  logic [DATA_WIDTH-1:0] reg_b_q, reg_b_d;
  logic [DATA_WIDTH-1:0] mem_q, mem_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [NUM_REQ-1:0]    res_vld_q, res_vld_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  err_spur_q, err_spur_d;
  logic                  err_movi_q, err_movi_d;

  op_t                   op_arr_s    [NUM_REQ];
  movi_t                 movi_arr_s  [NUM_REQ];
  logic [DATA_WIDTH-1:0] reg_a_arr_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] reg_b_arr_s [NUM_REQ];
  logic [DATA_WIDTH-1:0] mem_arr_s   [NUM_REQ];
  logic [DATA_WIDTH-1:0] imm_arr_s   [NUM_REQ];

  logic [NUM_REQ-1:0]    vld_rot_s;
  logic [ID_WIDTH-1:0]   off_s;
  logic [ID_WIDTH:0]     win_sum_s;
  logic [ID_WIDTH:0]     nxt_sum_s;
  logic                  win_found_s;
  logic [ID_WIDTH-1:0]   win_id_s;
  logic [ID_WIDTH-1:0]   rr_nxt_s;
  logic                  grant_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [ID_WIDTH-1:0]   head_id_s;
  logic [NUM_REQ-1:0]    req_rdy_s;

  // Split the packed request buses into per-requester fields.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      op_arr_s[k]    = op_t'(REQ_OP[4*k +: 4]);
      movi_arr_s[k]  = movi_t'(REQ_MOVI[2*k +: 2]);
      reg_a_arr_s[k] = REQ_REG_A[DATA_WIDTH*k +: DATA_WIDTH];
      reg_b_arr_s[k] = REQ_REG_B[DATA_WIDTH*k +: DATA_WIDTH];
      mem_arr_s[k]   = REQ_MEM[DATA_WIDTH*k +: DATA_WIDTH];
      imm_arr_s[k]   = REQ_IMM[DATA_WIDTH*k +: DATA_WIDTH];
    end
  end

  // Round-robin search: rotate valids so the pointer sits at bit 0, take the
  // lowest set bit, then map the offset back to an absolute requester ID.
  always_comb begin
    vld_rot_s   = NUM_REQ'({REQ_VLD, REQ_VLD} >> rr_ptr_q);
    win_found_s = 1'b0;
    off_s       = {ID_WIDTH{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (vld_rot_s[k]) begin
        win_found_s = 1'b1;
        off_s       = ID_WIDTH'(k);
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_sum_s = {1'b0, rr_ptr_q} + {1'b0, off_s};
    if (win_sum_s >= NUM_REQ_EXT) begin
      win_id_s = ID_WIDTH'(win_sum_s - NUM_REQ_EXT);
    end else begin
      win_id_s = ID_WIDTH'(win_sum_s);
    end
    nxt_sum_s = {1'b0, win_id_s} + (ID_WIDTH+1)'(1);
    if (nxt_sum_s >= NUM_REQ_EXT) begin
      rr_nxt_s = {ID_WIDTH{1'b0}};
    end else begin
      rr_nxt_s = ID_WIDTH'(nxt_sum_s);
    end
  end

  // Issue FSM next-state: grant and latch in IDLE, hold until accept in ISSUE.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    alu_act_d  = alu_act_q;
    op_d       = op_q;
    movi_d     = movi_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    mem_d      = mem_q;
    imm_d      = imm_q;
    err_movi_d = err_movi_q;
    grant_s    = 1'b0;
    push_s     = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (win_found_s && !fifo_full_s) begin
          grant_s   = 1'b1;
          state_d   = ARB_ISSUE;
          alu_act_d = 1'b1;
          id_d      = win_id_s;
          rr_ptr_d  = rr_nxt_s;
          op_d      = op_arr_s[win_id_s];
          movi_d    = movi_arr_s[win_id_s];
          reg_a_d   = reg_a_arr_s[win_id_s];
          reg_b_d   = reg_b_arr_s[win_id_s];
          mem_d     = mem_arr_s[win_id_s];
          imm_d     = imm_arr_s[win_id_s];
          if (is_rsvd_movi(movi_arr_s[win_id_s])) begin
            err_movi_d = 1'b1;
          end else begin
            err_movi_d = err_movi_q;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (ALU_RDY) begin
          push_s    = 1'b1;
          state_d   = ARB_IDLE;
          alu_act_d = 1'b0;
        end else begin
          state_d = ARB_ISSUE;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        alu_act_d = 1'b0;
      end
    endcase
  end

  // Accept strobe goes to the winner only in the cycle it is granted.
  always_comb begin
    req_rdy_s = {NUM_REQ{1'b0}};
    if (grant_s) begin
      req_rdy_s[win_id_s] = 1'b1;
    end else begin
      req_rdy_s = {NUM_REQ{1'b0}};
    end
  end

  // Result return: pop the oldest tag and steer the data; flag orphans.
  always_comb begin
    pop_s = ALU_EX_VLD && !fifo_empty_s;
    res_vld_d = {NUM_REQ{1'b0}};
    if (pop_s) begin
      res_vld_d[head_id_s] = 1'b1;
      res_data_d           = ALU_EX;
    end else begin
      res_data_d = res_data_q;
    end
    if (ALU_EX_VLD && fifo_empty_s) begin
      err_spur_d = 1'b1;
    end else begin
      err_spur_d = err_spur_q;
    end
  end

  alu_tag_fifo #(
    .TAG_WIDTH (ID_WIDTH),
    .DEPTH     (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push     (push_s),
    .push_tag (id_q),
    .pop      (pop_s),
    .pop_tag  (head_id_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (OUTSTANDING)
  );

  // Arbiter state, issue register, result register and sticky error flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= {ID_WIDTH{1'b0}};
      id_q       <= {ID_WIDTH{1'b0}};
      alu_act_q  <= 1'b0;
      op_q       <= 4'h0;
      movi_q     <= REG_B;
      reg_a_q    <= {DATA_WIDTH{1'b0}};
      reg_b_q    <= {DATA_WIDTH{1'b0}};
      mem_q      <= {DATA_WIDTH{1'b0}};
      imm_q      <= {DATA_WIDTH{1'b0}};
      res_vld_q  <= {NUM_REQ{1'b0}};
      res_data_q <= {DATA_WIDTH{1'b0}};
      err_spur_q <= 1'b0;
      err_movi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      alu_act_q  <= alu_act_d;
      op_q       <= op_d;
      movi_q     <= movi_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      mem_q      <= mem_d;
      imm_q      <= imm_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      err_spur_q <= err_spur_d;
      err_movi_q <= err_movi_d;
    end
  end

  assign REQ_RDY      = req_rdy_s;
  assign ALU_ACT      = alu_act_q;
  assign ALU_OP       = op_q;
  assign ALU_MOVI     = movi_q;
  assign ALU_REG_A    = reg_a_q;
  assign ALU_REG_B    = reg_b_q;
  assign ALU_MEM      = mem_q;
  assign ALU_IMM      = imm_q;
  assign RES_VLD      = res_vld_q;
  assign RES_DATA     = res_data_q;
  assign ERR_SPURIOUS = err_spur_q;
  assign ERR_MOVI     = err_movi_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_alu_req_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXO = 4;

  logic            CLK;
  logic            RST_N;
  logic [N-1:0]    REQ_VLD;
  logic [N-1:0]    REQ_RDY;
  logic [N*4-1:0]  REQ_OP;
  logic [N*2-1:0]  REQ_MOVI;
  logic [N*DW-1:0] REQ_REG_A, REQ_REG_B, REQ_MEM, REQ_IMM;
  logic            ALU_ACT;
  logic [3:0]      ALU_OP;
  logic [1:0]      ALU_MOVI;
  logic [DW-1:0]   ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM;
  logic            ALU_RDY;
  logic [DW-1:0]   ALU_EX;
  logic            ALU_EX_VLD;
  logic [N-1:0]    RES_VLD;
  logic [DW-1:0]   RES_DATA;
  logic [2:0]      OUTSTANDING;
  logic            ERR_SPURIOUS;
  logic            ERR_MOVI;

  alu_req_arbiter #(
    .DATA_WIDTH(DW), .NUM_REQ(N), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_OP(REQ_OP), .REQ_MOVI(REQ_MOVI),
    .REQ_REG_A(REQ_REG_A), .REQ_REG_B(REQ_REG_B), .REQ_MEM(REQ_MEM), .REQ_IMM(REQ_IMM),
    .ALU_ACT(ALU_ACT), .ALU_OP(ALU_OP), .ALU_MOVI(ALU_MOVI),
    .ALU_REG_A(ALU_REG_A), .ALU_REG_B(ALU_REG_B), .ALU_MEM(ALU_MEM), .ALU_IMM(ALU_IMM),
    .ALU_RDY(ALU_RDY), .ALU_EX(ALU_EX), .ALU_EX_VLD(ALU_EX_VLD),
    .RES_VLD(RES_VLD), .RES_DATA(RES_DATA), .OUTSTANDING(OUTSTANDING),
    .ERR_SPURIOUS(ERR_SPURIOUS), .ERR_MOVI(ERR_MOVI)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Requester-side stimulus state
  logic       r_vld  [N];
  logic [3:0] r_op   [N];
  logic [1:0] r_movi [N];
  logic [7:0] r_a [N], r_b [N], r_mem [N], r_imm [N];

  // Behavioural model state
  bit         m_busy;
  logic [3:0] m_op;
  logic [1:0] m_movi;
  logic [7:0] m_a, m_b, m_mem, m_imm;
  int         m_id, m_rr;
  int         m_tags[$];
  logic [3:0] m_res_vld;
  logic [7:0] m_res_data;
  bit         m_err_spur, m_err_movi;
  logic [3:0] last_exp_rdy, seen_rdy;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ_VLD[i]          = r_vld[i];
      REQ_OP[4*i +: 4]    = r_op[i];
      REQ_MOVI[2*i +: 2]  = r_movi[i];
      REQ_REG_A[8*i +: 8] = r_a[i];
      REQ_REG_B[8*i +: 8] = r_b[i];
      REQ_MEM[8*i +: 8]   = r_mem[i];
      REQ_IMM[8*i +: 8]   = r_imm[i];
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [1:0] mv,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] mem, input logic [7:0] imm);
    r_vld[i] = 1'b1; r_op[i] = op; r_movi[i] = mv;
    r_a[i] = a; r_b[i] = b; r_mem[i] = mem; r_imm[i] = imm;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      r_vld[i] = 1'b0; r_op[i] = 4'h0; r_movi[i] = 2'd0;
      r_a[i] = 8'h00; r_b[i] = 8'h00; r_mem[i] = 8'h00; r_imm[i] = 8'h00;
    end
    ALU_RDY = 1'b0; ALU_EX_VLD = 1'b0; ALU_EX = 8'h00;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_op = 4'h0; m_movi = 2'd0;
    m_a = 8'h00; m_b = 8'h00; m_mem = 8'h00; m_imm = 8'h00;
    m_id = 0; m_rr = 0; m_tags.delete();
    m_res_vld = 4'h0; m_res_data = 8'h00;
    m_err_spur = 1'b0; m_err_movi = 1'b0;
    last_exp_rdy = 4'h0;
  endtask

  // Called just after a falling edge with inputs prepared: compares outputs
  // with the model, advances the model across the next rising edge.
  task automatic tick();
    int w, id;
    bit found;
    logic [3:0] exp_rdy;
    drive();
    #1;
    found = 1'b0; w = 0;
    if (!m_busy && m_tags.size() < MAXO) begin
      for (int k = 0; k < N; k++) begin
        if (!found && r_vld[(m_rr + k) % N]) begin
          found = 1'b1;
          w = (m_rr + k) % N;
        end
      end
    end
    exp_rdy  = found ? 4'(1 << w) : 4'h0;
    seen_rdy = REQ_RDY;
    chk("req_rdy", REQ_RDY, exp_rdy);
    chk("alu_act", ALU_ACT, m_busy);
    if (m_busy) begin
      chk("alu_op", ALU_OP, m_op);
      chk("alu_movi", ALU_MOVI, m_movi);
      chk("alu_reg_a", ALU_REG_A, m_a);
      chk("alu_reg_b", ALU_REG_B, m_b);
      chk("alu_mem", ALU_MEM, m_mem);
      chk("alu_imm", ALU_IMM, m_imm);
    end
    chk("outstanding", OUTSTANDING, m_tags.size());
    chk("res_vld", RES_VLD, m_res_vld);
    chk("res_data", RES_DATA, m_res_data);
    chk("err_spurious", ERR_SPURIOUS, m_err_spur);
    chk("err_movi", ERR_MOVI, m_err_movi);

    if (ALU_EX_VLD) begin
      if (m_tags.size() > 0) begin
        id = m_tags.pop_front();
        m_res_vld  = 4'(1 << id);
        m_res_data = ALU_EX;
      end else begin
        m_res_vld  = 4'h0;
        m_err_spur = 1'b1;
      end
    end else begin
      m_res_vld = 4'h0;
    end
    if (m_busy) begin
      if (ALU_RDY) begin
        m_tags.push_back(m_id);
        m_busy = 1'b0;
      end
    end else if (found) begin
      m_busy = 1'b1; m_id = w;
      m_op = r_op[w]; m_movi = r_movi[w];
      m_a = r_a[w]; m_b = r_b[w]; m_mem = r_mem[w]; m_imm = r_imm[w];
      m_rr = (w + 1) % N;
      if (r_movi[w] == 2'd3) m_err_movi = 1'b1;
    end
    last_exp_rdy = exp_rdy;
    @(negedge CLK);
  endtask

  task automatic do_reset(input bit check);
    RST_N = 1'b0;
    clear_inputs();
    drive();
    #1;
    if (check) begin
      chk("rst_req_rdy", REQ_RDY, 0);
      chk("rst_alu_act", ALU_ACT, 0);
      chk("rst_alu_fields", {ALU_OP, ALU_MOVI, ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM}, 0);
      chk("rst_res_vld", RES_VLD, 0);
      chk("rst_res_data", RES_DATA, 0);
      chk("rst_outstanding", OUTSTANDING, 0);
      chk("rst_errs", {ERR_SPURIOUS, ERR_MOVI}, 0);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] exp_g [5];
    logic [3:0] got_g [5];
    int         cyc_g [5];
    int         gcount;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    RST_N = 1'b1;
    clear_inputs();
    drive();
    @(negedge CLK);
    do_reset(1'b1);

    // Single request, result three cycles after acceptance
    set_req(0, 4'h0, 2'd0, 8'h05, 8'h03, 8'h00, 8'h00);
    ALU_RDY = 1'b1;
    tick();
    chk("t1_grant", seen_rdy, 4'b0001);
    chk("t1_act", ALU_ACT, 1);
    chk("t1_reg_a", ALU_REG_A, 8'h05);
    chk("t1_reg_b", ALU_REG_B, 8'h03);
    r_vld[0] = 1'b0;
    tick();
    chk("t1_out1", OUTSTANDING, 1);
    tick();
    tick();
    ALU_EX_VLD = 1'b1; ALU_EX = 8'h08;
    tick();
    chk("t1_res_vld", RES_VLD, 4'b0001);
    chk("t1_res_data", RES_DATA, 8'h08);
    chk("t1_out0", OUTSTANDING, 0);
    ALU_EX_VLD = 1'b0;
    tick();
    chk("t1_res_idle", RES_VLD, 4'b0000);
    chk("t1_res_hold", RES_DATA, 8'h08);

    // Fairness with all requesters continuously valid
    do_reset(1'b0);
    for (int i = 0; i < N; i++) set_req(i, 4'(i), 2'd0, 8'(i), 8'h10, 8'h20, 8'h30);
    ALU_RDY = 1'b1;
    gcount = 0;
    for (int c = 0; c < 10; c++) begin
      ALU_EX_VLD = (m_tags.size() > 0);
      ALU_EX = 8'(c);
      tick();
      if (seen_rdy != 4'h0 && gcount < 5) begin
        got_g[gcount] = seen_rdy; cyc_g[gcount] = c; gcount++;
      end
    end
    chk("fair_count", gcount, 5);
    for (int g = 0; g < 5; g++) begin
      if (g < gcount) begin
        chk("fair_grant", got_g[g], exp_g[g]);
        chk("fair_gap", cyc_g[g], 2 * g);
      end
    end

    // Backpressure: five stalled cycles, accept on the sixth
    do_reset(1'b0);
    set_req(1, 4'h3, 2'd1, 8'hAA, 8'h55, 8'hC3, 8'h3C);
    ALU_RDY = 1'b0;
    tick();
    chk("bp_grant", seen_rdy, 4'b0010);
    r_vld[1] = 1'b0;
    set_req(2, 4'h9, 2'd2, 8'h01, 8'h02, 8'h03, 8'h04);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_rdy", seen_rdy, 4'b0000);
      chk("bp_act", ALU_ACT, 1);
      chk("bp_hold", {ALU_OP, ALU_MOVI, ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM},
          {4'h3, 2'd1, 8'hAA, 8'h55, 8'hC3, 8'h3C});
    end
    ALU_RDY = 1'b1;
    tick();
    chk("bp_accept", OUTSTANDING, 1);
    tick();
    chk("bp_next_grant", seen_rdy, 4'b0100);
    r_vld[2] = 1'b0;
    tick();

    // Tag FIFO full: results withheld
    do_reset(1'b0);
    for (int i = 0; i < N; i++) set_req(i, 4'h1, 2'd0, 8'(i), 8'h00, 8'h00, 8'h00);
    ALU_RDY = 1'b1;
    gcount = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (seen_rdy != 4'h0) gcount++;
    end
    chk("full_grants", gcount, 4);
    chk("full_outstanding", OUTSTANDING, 4);
    chk("full_rdy", seen_rdy, 4'b0000);
    ALU_EX_VLD = 1'b1; ALU_EX = 8'h5A;
    tick();
    chk("full_pop_res", RES_VLD, 4'b0001);
    ALU_EX_VLD = 1'b0;
    tick();
    chk("full_regrant", seen_rdy, 4'b0001);

    // Results steered back in issue order: requesters 2, 0, 3
    do_reset(1'b0);
    ALU_RDY = 1'b1;
    set_req(2, 4'h2, 2'd0, 8'h22, 8'h00, 8'h00, 8'h00); tick(); r_vld[2] = 1'b0; tick();
    set_req(0, 4'h0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00); tick(); r_vld[0] = 1'b0; tick();
    set_req(3, 4'h3, 2'd2, 8'h33, 8'h00, 8'h00, 8'hEE); tick(); r_vld[3] = 1'b0; tick();
    chk("ord_out", OUTSTANDING, 3);
    ALU_EX_VLD = 1'b1;
    ALU_EX = 8'h11; tick(); chk("ord_r0", RES_VLD, 4'b0100); chk("ord_d0", RES_DATA, 8'h11);
    ALU_EX = 8'h22; tick(); chk("ord_r1", RES_VLD, 4'b0001); chk("ord_d1", RES_DATA, 8'h22);
    ALU_EX = 8'h33; tick(); chk("ord_r2", RES_VLD, 4'b1000); chk("ord_d2", RES_DATA, 8'h33);
    ALU_EX_VLD = 1'b0;
    tick();
    chk("ord_idle", RES_VLD, 4'b0000);
    chk("ord_hold", RES_DATA, 8'h33);

    // Error flags and reset in the middle of an issue
    do_reset(1'b0);
    ALU_EX_VLD = 1'b1; ALU_EX = 8'h77;
    tick();
    chk("err_spur", ERR_SPURIOUS, 1);
    chk("err_spur_res", RES_VLD, 4'b0000);
    chk("err_spur_data", RES_DATA, 8'h00);
    ALU_EX_VLD = 1'b0;
    set_req(1, 4'h5, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04);
    ALU_RDY = 1'b1;
    tick();
    r_vld[1] = 1'b0;
    chk("err_movi", ERR_MOVI, 1);
    chk("err_movi_pass", ALU_MOVI, 2'd3);
    tick();
    set_req(2, 4'h6, 2'd0, 8'h09, 8'h08, 8'h07, 8'h06);
    ALU_RDY = 1'b0;
    tick();
    chk("mid_act", ALU_ACT, 1);
    chk("mid_out", OUTSTANDING, 1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_act", ALU_ACT, 0);
    chk("mid_rst_out", OUTSTANDING, 0);
    chk("mid_rst_errs", {ERR_SPURIOUS, ERR_MOVI}, 2'b00);
    clear_inputs();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    ALU_EX_VLD = 1'b1; ALU_EX = 8'h99;
    tick();
    chk("post_rst_spur", ERR_SPURIOUS, 1);
    ALU_EX_VLD = 1'b0;
    tick();

    // Randomized traffic with one reset partway through
    do_reset(1'b0);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset(1'b0);
      for (int i = 0; i < N; i++) begin
        if (last_exp_rdy[i] || !r_vld[i]) begin
          r_vld[i]  = ($urandom_range(0, 3) != 0);
          r_op[i]   = 4'($urandom_range(0, 15));
          r_movi[i] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          r_a[i]    = 8'($urandom_range(0, 255));
          r_b[i]    = 8'($urandom_range(0, 255));
          r_mem[i]  = 8'($urandom_range(0, 255));
          r_imm[i]  = 8'($urandom_range(0, 255));
        end
      end
      ALU_RDY    = ($urandom_range(0, 2) != 0);
      ALU_EX_VLD = (m_tags.size() > 0) && ($urandom_range(0, 2) == 0);
      ALU_EX     = 8'($urandom_range(0, 255));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
